// File: rtl/sinh_chuoi_pkg.sv
// Shared definitions for the 1011 serial pattern generator:
// FSM state encoding, default pattern and default widths.
package sinh_chuoi_pkg;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_GAP_W   = 4;
  localparam int         REP_W       = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Bit counter must hold PAT_W-1; never narrower than one bit.
  function automatic int bit_cnt_w(input int pat_w);
    return (pat_w < 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/sinh_chuoi_1011_pattern_shreg.sv
// PAT_W-bit shift register with parallel load and shift-left enable.
// The MSB is the serial bit currently presented on the line.
module sinh_chuoi_1011_pattern_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [PAT_W-1:0] i_pattern,
  output logic             o_msb
);

  logic [PAT_W-1:0] r_q;

  // Load has priority over shift; zeros enter from the LSB side.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_pattern;
    end else if (i_shift) begin
      r_q <= {r_q[PAT_W-2:0], 1'b0};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_msb = r_q[PAT_W-1];

endmodule

// File: rtl/sinh_chuoi_1011.sv
// Serial pattern generator: sends PATTERN MSB first rep_cnt times with
// gap idle zeros between repetitions, then pulses done for one cycle.
module sinh_chuoi_1011
  import sinh_chuoi_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               GAP_W   = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             start,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             w,
  output logic             busy,
  output logic             done
);

  localparam int               BCW      = bit_cnt_w(PAT_W);
  localparam logic [BCW-1:0]   BIT_LAST = BCW'(PAT_W - 1);
  localparam logic [BCW-1:0]   BIT_ONE  = BCW'(1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t           r_state;
  logic [BCW-1:0]   r_bit_cnt;
  logic [REP_W-1:0] r_rep_cnt;
  logic [GAP_W-1:0] r_gap_cfg;
  logic [GAP_W-1:0] r_gap_cnt;

  logic w_load;
  logic w_shift;
  logic w_msb;

  sinh_chuoi_1011_pattern_shreg #(
    .PAT_W (PAT_W)
  ) u_shreg (
    .clk       (clk),
    .rs        (rs),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_pattern (PATTERN),
    .o_msb     (w_msb)
  );

  // Shift register control: load at every pattern start, shift inside a pattern.
  always_comb begin
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (rep_cnt != '0)) begin
          w_load = 1'b1;
        end else begin
          w_load = 1'b0;
        end
      end
      S_SEND: begin
        if (abort) begin
          w_shift = 1'b0;
        end else if (r_bit_cnt != '0) begin
          w_shift = 1'b1;
        end else if ((r_rep_cnt != '0) && (r_gap_cfg == '0)) begin
          w_load = 1'b1;
        end else begin
          w_load = 1'b0;
        end
      end
      S_GAP: begin
        if (!abort && (r_gap_cnt == '0)) begin
          w_load = 1'b1;
        end else begin
          w_load = 1'b0;
        end
      end
      default: begin
        w_load  = 1'b0;
        w_shift = 1'b0;
      end
    endcase
  end

  // Burst sequencer; every counter is tested against zero before decrementing.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      r_gap_cfg <= '0;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (rep_cnt != '0) begin
              r_state   <= S_SEND;
              r_bit_cnt <= BIT_LAST;
              r_rep_cnt <= rep_cnt - REP_ONE;
              r_gap_cfg <= gap;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (r_bit_cnt != '0) begin
            r_bit_cnt <= r_bit_cnt - BIT_ONE;
          end else if (r_rep_cnt == '0) begin
            r_state <= S_DONE;
          end else if (r_gap_cfg == '0) begin
            r_rep_cnt <= r_rep_cnt - REP_ONE;
            r_bit_cnt <= BIT_LAST;
          end else begin
            r_state   <= S_GAP;
            r_gap_cnt <= r_gap_cfg - GAP_ONE;
          end
        end
        S_GAP: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end else begin
            r_state   <= S_SEND;
            r_rep_cnt <= r_rep_cnt - REP_ONE;
            r_bit_cnt <= BIT_LAST;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore decode: outputs depend only on flops, never on inputs.
  assign w    = (r_state == S_SEND) && w_msb;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: doc/sinh_chuoi_1011.md
# sinh_chuoi_1011

Serial pattern generator, the transmit-side counterpart of the team's 1011 sequence detection. On a start request it shifts out a PAT_W-bit pattern (default 1011) MSB first on a single serial line. It repeats the pattern a programmed number of times, with a programmable run of idle zeros between repetitions, then pulses done. It sits in front of any `w`-input sequence detector as stimulus and loopback source.

## Interface
- PAT_W, 4, pattern length in bits (2..16)
- PATTERN, 4'b1011, bit pattern transmitted MSB first
- GAP_W, 4, width of the gap-length input
- clk  input  1  rising-edge clock
- rs  input  1  reset, asynchronous, active-low
- start  input  1  request a burst; sampled only in IDLE
- rep_cnt  input  4  number of pattern repetitions, latched on accepted start
- gap  input  GAP_W  idle-zero cycles between repetitions, latched on accepted start
- abort  input  1  synchronous cancel of a burst in progress
- w  output  1  serial data bit
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at normal burst completion

## Operation
- Moore FSM with states IDLE, SEND, GAP, DONE. All outputs decode from the state and the shift register only.
- IDLE:
  - start=1 and rep_cnt≠0: load the shift register with PATTERN, bit counter with PAT_W-1, rep counter with rep_cnt-1, gap register with gap. Go to SEND.
  - start=1 and rep_cnt=0: go to DONE. No bits are sent.
  - Otherwise stay in IDLE.
- SEND:
  - w = shift register MSB. Shift left by one each cycle and decrement the bit counter.
  - When the bit counter is 0 and the rep counter is 0, go to DONE.
  - When the bit counter is 0, the rep counter is nonzero and gap=0: reload PATTERN, decrement the rep counter, stay in SEND. This gives back-to-back patterns.
  - When the bit counter is 0, the rep counter is nonzero and gap≠0: go to GAP with the gap counter loaded to gap-1.
- GAP:
  - w=0. Decrement the gap counter.
  - At 0: reload PATTERN, decrement the rep counter, go to SEND.
- DONE: w=0, done=1, busy=1. Next state is unconditionally IDLE.
- abort=1 in SEND, GAP or DONE: next state is IDLE and done is not asserted. abort in IDLE is ignored.
- abort and start high together in IDLE: start wins, because abort is ignored in IDLE.
- start while busy is ignored; it is not queued.
- rep_cnt and gap changes after acceptance have no effect on the burst in flight.
- w=0 in IDLE, GAP and DONE.

## Timing
- Reset (rs=0, asynchronous): state=IDLE, shift register=0, all counters=0. Outputs are w=0, busy=0, done=0.
- Reset deassertion takes effect on the next rising clk edge.
- Reset asserted mid-burst aborts immediately and asynchronously; done is not asserted.
- Latency: start sampled high at edge k. The first pattern bit appears on w in the cycle after edge k, with busy=1 from that cycle.
- Each bit is held exactly one cycle.
- Burst length: busy stays high for rep_cnt·PAT_W + (rep_cnt-1)·gap cycles, plus 1 DONE cycle.
- done is high for exactly one cycle and coincides with the last busy cycle.
- The earliest next start is accepted at the edge that returns the FSM to IDLE plus one, i.e. start must be sampled while in IDLE.
- Counter widths:
  - bit counter: $clog2(PAT_W)
  - rep counter: 4 bits
  - gap counter: GAP_W
- No counter wraps: every counter is compared to 0 before it is decremented.

## Structure
- Package sinh_chuoi_pkg holds:
  - state encoding constants S_IDLE=0, S_SEND=1, S_GAP=2, S_DONE=3 (2-bit state)
  - default PATTERN
  - default widths
- One natural sub-module: pattern_shreg. It is a PAT_W-bit shift register with parallel load, shift-left enable and an MSB output, reset asynchronously by rs.
- The FSM and counters stay in the top.

## Test plan
- Single burst: rep_cnt=1, gap=0, start pulsed one cycle → w=1,0,1,1 on four consecutive cycles, then done=1 for one cycle with w=0, then busy=0.
- Repeat with gap: rep_cnt=3, gap=2 → w stream 1011 00 1011 00 1011, busy high for 16+1 cycles, done high in cycle 17 only.
- Back-to-back: rep_cnt=2, gap=0 → 10111011, then one done cycle.
- Zero reps: rep_cnt=0, start=1 → busy=1 and done=1 in the next cycle, w stays 0, then IDLE.
- Abort and reissue:
  - Assert abort on the 3rd bit of rep 2 of a rep_cnt=3 burst → next cycle busy=0, w=0, no done.
  - start during the burst has no effect.
  - A new start afterwards produces a clean 1011.
- Async reset mid-GAP: drop rs between clock edges → w, busy and done go 0 immediately without a clock. After release, one start with rep_cnt=1 yields 1011 and done.
